wifi_tx_frame_ctrl: RTL
=======================

Name: wifi_tx_frame_ctrl

Overview:
Frame sequencer in front of the serial Wi-Fi TX datapath (one bit per transfer on its data_in).
- Takes a frame request (payload length) and a byte stream from the MAC side.
- Emits one serial bit stream: preamble, length header, payload, tail, with per-bit valid/ready backpressure from the datapath.
- Sits between the MAC byte buffer and the TX bit pipeline and owns frame start/end signalling.

Parameters:
PREAMBLE_BITS, 16, preamble length in bits; pattern is alternating, first bit 1.
TAIL_BITS, 6, number of zero tail bits after the payload.
LEN_W, 12, width of the payload byte-count field and of the transmitted header.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  frame request pulse; sampled only in IDLE
len  input  LEN_W  payload length in bytes, sampled with start
abort  input  1  terminate current frame, return to IDLE next cycle
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last tail bit transfers
s_data  input  8  payload byte
s_valid  input  1  s_data valid
s_ready  output  1  byte accepted when s_valid && s_ready
tx_ready  input  1  datapath accepts the current bit
tx_bit  output  1  serial bit to the datapath (its data_in)
tx_valid  output  1  tx_bit valid
tx_sof  output  1  high with the first preamble bit
tx_eof  output  1  high with the last tail bit

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, s_ready, tx_bit, tx_valid, tx_sof, tx_eof = 0; counters and holding register cleared and marked empty. Reset overrides abort and start.
- A bit transfer occurs on a cycle where tx_valid && tx_ready. tx_bit, tx_sof and tx_eof hold stable while tx_valid=1 and tx_ready=0.
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, TAIL.
- IDLE:
  - When start=1 on edge T: latch len and go to PREAMBLE. Outputs then show tx_valid=1, tx_bit=1, tx_sof=1 during cycle T+1.
  - start is ignored outside IDLE.
- PREAMBLE: bit k (0-based) = ~k[0]. After PREAMBLE_BITS transfers, go to HEADER.
- HEADER: LEN_W bits of the latched len, LSB first. After the last header transfer:
  - go to PAYLOAD if len≠0;
  - go to TAIL if len=0 (no payload bits, s_ready stays 0).
- Byte fetch:
  - One-byte holding register.
  - s_ready = (state∈{HEADER,PAYLOAD}) && holding empty && bytes_fetched<len.
  - Prefetch during HEADER removes the bubble at the payload start.
- PAYLOAD:
  - Bytes are serialized LSB first. The holding register loads an 8-bit shifter when the shifter empties.
  - If the shifter and holding register are both empty (underrun): tx_valid=0 until a byte arrives. There is no error and no bit loss.
  - After len×8 transfers, go to TAIL.
- TAIL:
  - TAIL_BITS zero bits; tx_eof=1 on the last one.
  - On its transfer: go to IDLE, done=1 for the following cycle, busy=0 in that same cycle.
- abort=1 in any non-IDLE state:
  - Next cycle: state=IDLE, tx_valid=0, s_ready=0, holding register flushed, no done pulse.
  - A bit transferring in the abort cycle counts as sent.
  - abort in IDLE has no effect.
- Counters: bit counter sized for max(PREAMBLE_BITS, LEN_W, 8, TAIL_BITS); byte counter LEN_W bits.
- len = 2^LEN_W−1 must work without wrap.

Test Plan:
- Reset check: assert reset for 3 cycles mid-PAYLOAD -> all outputs 0, state IDLE; a following start works normally.
- Nominal frame: len=2, bytes 0xA5, 0x3C, tx_ready=1 always -> 16-bit preamble 1010…, header 0x002 LSB-first, payload bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, then 6 zeros. Total 16+12+16+6=50 contiguous valid bits; tx_sof on bit 0, tx_eof on bit 49, done 1 cycle after.
- Backpressure: same frame, tx_ready toggling 1/0 every cycle -> identical bit sequence; tx_bit stable across stall cycles; 50 transfers.
- Underrun: len=1, s_valid withheld for 5 cycles after the header -> tx_valid=0 for those cycles, then 8 payload bits, correct tail, done.
- len=0 -> preamble + header 0x000 + 6 tail bits (34 bits); s_ready never asserts.
- Abort/start-while-busy: start during HEADER ignored; abort at payload bit 3 -> tx_valid=0 and busy=0 next cycle, no done; the next frame starts cleanly with a fresh preamble.

Source files
------------

// File: rtl/wifi_tx_frame_ctrl.sv
// Frame sequencer for the serial Wi-Fi TX datapath: emits preamble, LSB-first length
// header, LSB-first payload bytes and zero tail as one valid/ready bit stream.
module wifi_tx_frame_ctrl #(
    parameter int PREAMBLE_BITS = 16,
    parameter int TAIL_BITS     = 6,
    parameter int LEN_W         = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             tx_ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             tx_sof,
    output logic             tx_eof
);

    localparam int M1    = (PREAMBLE_BITS > LEN_W) ? PREAMBLE_BITS : LEN_W;
    localparam int M2    = (M1 > 8) ? M1 : 8;
    localparam int MAXB  = (M2 > TAIL_BITS) ? M2 : TAIL_BITS;
    localparam int CNT_W = $clog2(MAXB + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_TAIL
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [LEN_W-1:0] r_fetched;
    logic [LEN_W-1:0] r_sent;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic [7:0]       r_sh;
    logic [3:0]       r_sh_cnt;
    logic             r_done;

    logic             w_xfer;
    logic             w_s_acc;
    logic             w_byte_last;
    logic             w_sh_free;
    logic             w_hdr_bit;
    logic             w_fetch_ok;
    logic             w_frame_end;
    logic             w_abort;

    assign w_xfer      = tx_valid && tx_ready;
    assign w_s_acc     = s_valid && s_ready;
    assign w_byte_last = (r_sh_cnt == 4'd1);
    assign w_hdr_bit   = |(r_len & (LEN_W'(1) << r_bit_cnt));
    assign w_fetch_ok  = !r_hold_full && (r_fetched < r_len);
    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_frame_end = (r_state == S_TAIL) && w_xfer && (r_bit_cnt == TAIL_LAST);
    // Shifter is free this edge if empty, or if its last bit is leaving now.
    assign w_sh_free   = (r_sh_cnt == 4'd0) ||
                         (w_byte_last && w_xfer && (r_state == S_PAYLOAD));
    assign done        = r_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = (r_state != S_IDLE);
        tx_valid = 1'b0;
        tx_bit   = 1'b0;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        s_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                tx_valid = 1'b1;
                tx_bit   = ~r_bit_cnt[0];
                tx_sof   = (r_bit_cnt == '0);
                if (w_xfer && (r_bit_cnt == PRE_LAST)) w_next = S_HEADER;
            end
            S_HEADER: begin
                tx_valid = 1'b1;
                tx_bit   = w_hdr_bit;
                s_ready  = w_fetch_ok;
                if (w_xfer && (r_bit_cnt == HDR_LAST))
                    w_next = (r_len == '0) ? S_TAIL : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                tx_valid = (r_sh_cnt != 4'd0);
                tx_bit   = r_sh[0];
                s_ready  = w_fetch_ok;
                if (w_xfer && w_byte_last && (r_sent == r_len - LEN_W'(1)))
                    w_next = S_TAIL;
            end
            S_TAIL: begin
                tx_valid = 1'b1;
                tx_eof   = (r_bit_cnt == TAIL_LAST);
                if (w_xfer && (r_bit_cnt == TAIL_LAST)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_len       <= '0;
            r_bit_cnt   <= '0;
            r_fetched   <= '0;
            r_sent      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_sh        <= '0;
            r_sh_cnt    <= 4'd0;
            r_done      <= 1'b0;
        end else if (w_abort) begin
            r_bit_cnt   <= '0;
            r_fetched   <= '0;
            r_sent      <= '0;
            r_hold_full <= 1'b0;
            r_sh_cnt    <= 4'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (r_state == S_IDLE) begin
                r_fetched   <= '0;
                r_sent      <= '0;
                r_hold_full <= 1'b0;
                r_sh_cnt    <= 4'd0;
                if (start) r_len <= len;
            end

            if (w_next != r_state)
                r_bit_cnt <= '0;
            else if (w_xfer && (r_state != S_PAYLOAD))
                r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_s_acc) r_fetched <= r_fetched + 1'b1;

            if ((r_state == S_PAYLOAD) && w_xfer) begin
                r_sh     <= r_sh >> 1;
                r_sh_cnt <= r_sh_cnt - 4'd1;
                if (w_byte_last) r_sent <= r_sent + 1'b1;
            end

            // A byte bypasses the holding register when the shifter is free for it.
            if (w_sh_free && r_hold_full) begin
                r_sh        <= r_hold;
                r_sh_cnt    <= 4'd8;
                r_hold_full <= 1'b0;
            end else if (w_sh_free && w_s_acc) begin
                r_sh     <= s_data;
                r_sh_cnt <= 4'd8;
            end else if (w_s_acc) begin
                r_hold      <= s_data;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule
